// File: rtl/psum_drain_buffer.sv
// Drain buffer between the systolic array output rows and scratchpad writeback.
// Collects one tile of N rows in a register FIFO, flags ordering/overflow faults, pulses tile_done.
module psum_drain_buffer #(
  parameter int N     = 4,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                                CLK,
  input  logic                                nrst,
  input  logic                                out_en,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] row_out,
  input  logic [N*DW-1:0]                     array_output,
  input  logic                                psum_ready,
  output logic                                psum_valid,
  output logic [N*DW-1:0]                     psum_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] psum_row,
  output logic                                fifo_has_space,
  output logic                                tile_done,
  output logic                                overflow,
  output logic                                row_err
);

  // state | meaning
  // IDLE  | no rows of the current tile accepted yet
  // FILL  | accepting rows, fewer than N pushed so far
  // FLUSH | all N rows pushed, draining until N pops complete

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t          state;
  logic [N*DW-1:0] mem_data [DEPTH];
  logic [RW-1:0]   mem_row  [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic [RW-1:0]   push_cnt, pop_cnt;
  logic            push, pop;

  assign psum_valid     = (count != '0);
  assign psum_data      = mem_data[rptr];
  assign psum_row       = mem_row[rptr];
  assign fifo_has_space = (count < CNT_FULL) && (state != FLUSH);
  assign push           = out_en && fifo_has_space;
  assign pop            = psum_valid && psum_ready;

  // Entry storage needs no reset; psum_valid gates its visibility.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wptr] <= array_output;
      mem_row[wptr]  <= row_out;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      push_cnt  <= '0;
      pop_cnt   <= '0;
      tile_done <= 1'b0;
      overflow  <= 1'b0;
      row_err   <= 1'b0;
    end else begin
      tile_done <= 1'b0;

      if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (out_en && !fifo_has_space) overflow <= 1'b1;
      if (push && (row_out != push_cnt)) row_err <= 1'b1;

      // push only happens outside FLUSH and the tile-closing pop only inside it,
      // so the two state updates below never collide.
      if (push) begin
        if (push_cnt == ROW_LAST) begin
          push_cnt <= '0;
          state    <= FLUSH;
        end else begin
          push_cnt <= push_cnt + 1'b1;
          if (state == IDLE) state <= FILL;
        end
      end

      if (pop) begin
        if ((state == FLUSH) && (pop_cnt == ROW_LAST)) begin
          pop_cnt   <= '0;
          tile_done <= 1'b1;
          state     <= IDLE;
        end else begin
          pop_cnt <= pop_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_drain_buffer.sv
// Directed bench for psum_drain_buffer (N=4, DW=16, DEPTH=4) with hand-computed expectations.
module tb_psum_drain_buffer;

  logic        CLK = 1'b0;
  logic        nrst;
  logic        out_en;
  logic [1:0]  row_out;
  logic [63:0] array_output;
  logic        psum_ready;
  logic        psum_valid;
  logic [63:0] psum_data;
  logic [1:0]  psum_row;
  logic        fifo_has_space;
  logic        tile_done;
  logic        overflow;
  logic        row_err;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [63:0] BASE = 64'h0001_0002_0003_0004;

  psum_drain_buffer #(.N(4), .DW(16), .DEPTH(4)) dut (
    .CLK            (CLK),
    .nrst           (nrst),
    .out_en         (out_en),
    .row_out        (row_out),
    .array_output   (array_output),
    .psum_ready     (psum_ready),
    .psum_valid     (psum_valid),
    .psum_data      (psum_data),
    .psum_row       (psum_row),
    .fifo_has_space (fifo_has_space),
    .tile_done      (tile_done),
    .overflow       (overflow),
    .row_err        (row_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
  endtask

  initial begin
    nrst = 1'b0; out_en = 1'b0; row_out = '0; array_output = '0; psum_ready = 1'b0;
    step();
    do_reset();
    chk("rst_valid", 64'(psum_valid), 64'd0);
    chk("rst_space", 64'(fifo_has_space), 64'd1);
    chk("rst_done", 64'(tile_done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_rowerr", 64'(row_err), 64'd0);

    // fill one tile with no drain
    for (int k = 0; k < 4; k++) begin
      out_en = 1'b1; row_out = 2'(k); array_output = BASE + 64'(k);
      step();
      if (k == 0) chk("fill_valid_1st", 64'(psum_valid), 64'd1);
    end
    out_en = 1'b0;
    chk("fill_full_space", 64'(fifo_has_space), 64'd0);
    chk("fill_no_ovf", 64'(overflow), 64'd0);

    // drain in order
    psum_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_row", 64'(psum_row), 64'(k));
      chk("drain_data", psum_data, BASE + 64'(k));
      chk("drain_done_low", 64'(tile_done), 64'd0);
      step();
    end
    psum_ready = 1'b0;
    chk("drain_done_pulse", 64'(tile_done), 64'd1);
    chk("drain_space", 64'(fifo_has_space), 64'd1);
    chk("drain_empty", 64'(psum_valid), 64'd0);
    step();
    chk("drain_done_once", 64'(tile_done), 64'd0);

    // streaming push+pop, occupancy stays at one
    psum_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      out_en = 1'b1; row_out = 2'(k); array_output = 64'h100 + 64'(k);
      step();
      chk("stream_valid", 64'(psum_valid), 64'd1);
      chk("stream_row", 64'(psum_row), 64'(k));
      chk("stream_data", psum_data, 64'h100 + 64'(k));
    end
    out_en = 1'b0;
    step();
    chk("stream_done", 64'(tile_done), 64'd1);
    chk("stream_empty", 64'(psum_valid), 64'd0);
    chk("stream_no_ovf", 64'(overflow), 64'd0);
    psum_ready = 1'b0;

    // offer a row into a full FIFO while popping: dropped, overflow sticky
    for (int k = 0; k < 4; k++) begin
      out_en = 1'b1; row_out = 2'(k); array_output = 64'h200 + 64'(k);
      step();
    end
    row_out = 2'd0; array_output = 64'hDEAD; psum_ready = 1'b1;
    step();
    out_en = 1'b0;
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_space", 64'(fifo_has_space), 64'd0);
    for (int k = 1; k < 4; k++) begin
      chk("full_row", 64'(psum_row), 64'(k));
      chk("full_data", psum_data, 64'h200 + 64'(k));
      step();
    end
    psum_ready = 1'b0;
    chk("full_occ3_empty", 64'(psum_valid), 64'd0);
    chk("full_done", 64'(tile_done), 64'd1);
    chk("full_ovf_sticky", 64'(overflow), 64'd1);

    // out-of-order row index
    do_reset();
    chk("err_rst_ovf", 64'(overflow), 64'd0);
    out_en = 1'b1; row_out = 2'd0; array_output = 64'h300;
    step();
    chk("err_first_ok", 64'(row_err), 64'd0);
    row_out = 2'd2; array_output = 64'h302;
    step();
    out_en = 1'b0;
    chk("err_flag", 64'(row_err), 64'd1);
    chk("err_head_row", 64'(psum_row), 64'd0);
    chk("err_head_data", psum_data, 64'h300);

    // a reset glitch between edges must not take effect
    #2 nrst = 1'b0;
    #2 nrst = 1'b1;
    step();
    chk("sync_valid", 64'(psum_valid), 64'd1);
    chk("sync_rowerr", 64'(row_err), 64'd1);

    // reset with two entries held in FILL
    do_reset();
    chk("mid_valid", 64'(psum_valid), 64'd0);
    chk("mid_done", 64'(tile_done), 64'd0);
    chk("mid_rowerr", 64'(row_err), 64'd0);
    chk("mid_space", 64'(fifo_has_space), 64'd1);
    step();
    chk("mid_no_done", 64'(tile_done), 64'd0);
    // counters restarted: a fresh 0..3 tile is clean and fills exactly
    for (int k = 0; k < 4; k++) begin
      out_en = 1'b1; row_out = 2'(k); array_output = 64'h400 + 64'(k);
      step();
      if (k < 3) chk("mid_fill_space", 64'(fifo_has_space), 64'd1);
    end
    out_en = 1'b0;
    chk("mid_refill_full", 64'(fifo_has_space), 64'd0);
    chk("mid_refill_rowerr", 64'(row_err), 64'd0);
    chk("mid_refill_head", psum_data, 64'h400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psum_drain_buffer.md
PSUM_DRAIN_BUFFER -- requirements
Module: psum_drain_buffer

Interface
REQ-001 Parameter N, default 4, systolic array dimension (rows per tile, elements per row).
REQ-002 Parameter DW, default 16, bits per partial-sum element.
REQ-003 Parameter DEPTH, default 4, FIFO entries; the block SHALL require DEPTH >= N.
REQ-004 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 nrst  input  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-006 out_en  input  1  systolic array output row valid.
REQ-007 row_out  input  $clog2(N)  row index of the presented output row.
REQ-008 array_output  input  N*DW  output row data; element 0 in bits [DW-1:0].
REQ-009 psum_ready  input  1  scratchpad writeback accepts the head entry.
REQ-010 psum_valid  output  1  FIFO head entry is valid.
REQ-011 psum_data  output  N*DW  head entry data.
REQ-012 psum_row  output  $clog2(N)  head entry row index.
REQ-013 fifo_has_space  output  1  block can accept a row this cycle (backpressure to array).
REQ-014 tile_done  output  1  one-cycle pulse when the last row of a tile leaves the FIFO.
REQ-015 overflow  output  1  sticky: a row was offered while it could not be accepted.
REQ-016 row_err  output  1  sticky: an accepted row index did not match the expected index.

Function
REQ-017 The FIFO SHALL store {row_out, array_output} per entry, in order; storage is registers, head is read combinationally.
REQ-018 Push SHALL occur iff out_en=1 and fifo_has_space=1 at the rising edge; pop SHALL occur iff psum_valid=1 and psum_ready=1.
REQ-019 fifo_has_space SHALL equal (occupancy < DEPTH) and (state != FLUSH), evaluated from state before the edge; a pop in the same cycle SHALL NOT enable a push into a full FIFO.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 psum_valid SHALL assert in the cycle after the push edge (one-cycle latency) and equal (occupancy != 0).
REQ-022 out_en=1 with fifo_has_space=0 SHALL drop the row and set overflow to 1 until reset.
REQ-023 A push counter (0..N-1) SHALL give the expected row index; an accepted row with row_out != counter SHALL set row_err to 1 until reset; data is still stored.
REQ-024 FSM states: IDLE, FILL, FLUSH.
REQ-025 IDLE -> FILL on any push; if N == 1 the push SHALL go directly to FLUSH.
REQ-026 FILL -> FLUSH on the push that makes the push counter reach N; the push counter then clears to 0.
REQ-027 FLUSH: no pushes accepted; a pop counter counts pops; on the pop making it N, tile_done=1 for exactly that next cycle, the pop counter clears, and the FSM returns to IDLE.
REQ-028 Pops in IDLE/FILL SHALL increment the pop counter; tile_done SHALL fire only from FLUSH.
REQ-029 tile_done SHALL be registered, asserting in the cycle after the final pop edge.

Reset
REQ-030 With nrst=0 at an edge: FSM=IDLE, pointers, occupancy and counters = 0, psum_valid=0, tile_done=0, overflow=0, row_err=0, fifo_has_space=1 after that edge.
REQ-031 Reset mid-tile SHALL discard all entries with no tile_done pulse; psum_data is don't-care while psum_valid=0.
REQ-032 nrst SHALL have no effect between edges (no asynchronous path).

Verification
REQ-033 Reset, then 4 rows (row_out 0..3, data 0x0001_0002_0003_0004+k) with psum_ready=0 -> psum_valid=1 one cycle after the first push; fifo_has_space=0 after the 4th push; state FLUSH.
REQ-034 Continue: psum_ready=1 for 4 cycles -> rows pop in order 0..3 with matching data; tile_done high exactly one cycle after the 4th pop; fifo_has_space=1 again.
REQ-035 Streaming: out_en every cycle with psum_ready=1 -> occupancy stays 1, data out 1 cycle later, no overflow.
REQ-036 FIFO full, out_en=1 with psum_ready=1 same cycle -> row dropped, overflow=1 sticky, occupancy 3.
REQ-037 Rows pushed as 0,2,... -> row_err=1 on the second push, both entries stored.
REQ-038 nrst=0 with 2 entries in FILL -> next cycle psum_valid=0, tile_done=0, sticky flags 0, FSM IDLE.
